// File: rtl/store_aligner.sv
// Store aligner: splits byte/halfword/word stores into one or two
// word-aligned memory beats with little-endian byte-lane placement.
module store_aligner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        misaligned,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  opc_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    function automatic logic [3:0] size_mask(input logic [4:0] op);
        logic is_word;
        logic is_half;
        logic is_byte;
        logic [3:0] m;
        is_word = (op >= 5'd3) && (op <= 5'd5);
        is_half = (op >= 5'd6) && (op <= 5'd8);
        is_byte = (op >= 5'd9) && (op <= 5'd11);
        m = 4'b0000;
        unique case (1'b1)
            is_word: m = 4'b1111;
            is_half: m = 4'b0011;
            is_byte: m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Lanes are placed in an 8-byte window spanning both candidate beats;
    // the upper half of the window is the second beat.
    function automatic logic [3:0] beat_be(
        input logic [4:0] op,
        input logic [1:0] off,
        input logic       hi
    );
        logic [7:0] be8;
        be8 = {4'b0000, size_mask(op)} << off;
        return hi ? be8[7:4] : be8[3:0];
    endfunction

    function automatic logic [31:0] beat_data(
        input logic [4:0]  op,
        input logic [1:0]  off,
        input logic [31:0] d,
        input logic        hi
    );
        logic [3:0]  m;
        logic [31:0] dm;
        logic [63:0] w;
        m  = size_mask(op);
        dm = d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        w  = {32'h0, dm} << {off, 3'b000};
        return hi ? w[63:32] : w[31:0];
    endfunction

    logic [3:0]  in_be1;
    logic [3:0]  in_be2;
    logic [31:0] in_wd1;
    logic        in_store;
    logic [3:0]  cap_be2;
    logic [31:0] cap_wd2;
    logic [31:0] cap_addr2;

    always_comb begin
        in_be1    = beat_be(opcode, addr[1:0], 1'b0);
        in_be2    = beat_be(opcode, addr[1:0], 1'b1);
        in_wd1    = beat_data(opcode, addr[1:0], data, 1'b0);
        in_store  = |size_mask(opcode);
        cap_be2   = beat_be(opc_q, addr_q[1:0], 1'b1);
        cap_wd2   = beat_data(opc_q, addr_q[1:0], data_q, 1'b1);
        cap_addr2 = {addr_q[31:2], 2'b00} + 32'd4;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opc_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            misaligned <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opc_q  <= opcode;
                        addr_q <= addr;
                        data_q <= data;
                        if (in_store) begin
                            state      <= BEAT1;
                            mem_req    <= 1'b1;
                            mem_addr   <= {addr[31:2], 2'b00};
                            mem_be     <= in_be1;
                            mem_wdata  <= in_wd1;
                            misaligned <= |in_be2;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        if (misaligned) begin
                            state     <= BEAT2;
                            mem_addr  <= cap_addr2;
                            mem_be    <= cap_be2;
                            mem_wdata <= cap_wd2;
                        end else begin
                            state      <= IDLE;
                            mem_req    <= 1'b0;
                            mem_addr   <= '0;
                            mem_be     <= '0;
                            mem_wdata  <= '0;
                            misaligned <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                BEAT2: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_addr   <= '0;
                        mem_be     <= '0;
                        mem_wdata  <= '0;
                        misaligned <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Self-checking bench for store_aligner: directed table, byte-level
// reference model with random stores and ack stalls, reset abort.
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        misaligned;
    logic        done;

    store_aligner dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .addr(addr), .data(data),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .misaligned(misaligned),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] w;
    } beat_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          nb;
        beat_t       b1;
        beat_t       b2;
    } vec_t;

    int    total = 0;
    int    bad = 0;
    beat_t exp_q[$];
    vec_t  tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Store as a sequence of bytes at addr+i, grouped by word address.
    function automatic void model(input logic [4:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] d);
        int n;
        logic [31:0] ba;
        logic [31:0] wa;
        beat_t b;
        exp_q.delete();
        if (op >= 3 && op <= 5) n = 4;
        else if (op >= 6 && op <= 8) n = 2;
        else if (op >= 9 && op <= 11) n = 1;
        else n = 0;
        for (int i = 0; i < n; i++) begin
            ba = a + i;
            wa = {ba[31:2], 2'b00};
            if (exp_q.size() == 0 || exp_q[exp_q.size()-1].a != wa) begin
                b.a = wa;
                b.be = '0;
                b.w = '0;
                exp_q.push_back(b);
            end
            b = exp_q[exp_q.size()-1];
            b.be[ba[1:0]] = 1'b1;
            b.w[ba[1:0]*8 +: 8] = d[i*8 +: 8];
            exp_q[exp_q.size()-1] = b;
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_store(input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int dlo,
                            input int dhi);
        int cyc;
        int idx;
        int cnt;
        int expdone;
        bit stall;
        bit two;
        logic [31:0] ha;
        logic [31:0] hw;
        logic [3:0]  hb;
        two = (exp_q.size() == 2);
        chk("in_ready", in_ready, 1);
        in_valid = 1'b1;
        opcode = op;
        addr = a;
        data = d;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; idx = 0; cnt = 0; stall = 0; expdone = 1;
        ha = '0; hw = '0; hb = '0;
        while (done !== 1'b1 && cyc < 60) begin
            if (mem_req) begin
                if (!stall) begin
                    if (idx < exp_q.size()) begin
                        chk("beat_addr", mem_addr, exp_q[idx].a);
                        chk("beat_be", mem_be, exp_q[idx].be);
                        chk("beat_wdata", mem_wdata, exp_q[idx].w);
                    end else begin
                        chk("extra_beat", idx, exp_q.size());
                    end
                    cnt = $urandom_range(dhi, dlo);
                    expdone += cnt + 1;
                    ha = mem_addr; hb = mem_be; hw = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, ha);
                    chk("hold_be", mem_be, hb);
                    chk("hold_wdata", mem_wdata, hw);
                end
                chk("misaligned", misaligned, two);
                if (cnt == 0) begin
                    mem_ack = 1'b1; stall = 0; idx++;
                end else begin
                    mem_ack = 1'b0; cnt--; stall = 1;
                end
            end else begin
                mem_ack = 1'($urandom_range(1, 0));
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        chk("done_seen", done, 1);
        chk("done_cycle", cyc, expdone);
        chk("beat_count", idx, exp_q.size());
        chk("misaligned_idle", misaligned, 0);
        chk("req_idle", mem_req, 0);
    endtask

    initial begin
        tbl[0]  = '{5'd3,  32'h100,      32'hAABBCCDD, 1,
                    '{32'h100, 4'hF, 32'hAABBCCDD}, '{0, 0, 0}};
        tbl[1]  = '{5'd4,  32'h101,      32'h11223344, 2,
                    '{32'h100, 4'hE, 32'h22334400},
                    '{32'h104, 4'h1, 32'h00000011}};
        tbl[2]  = '{5'd7,  32'h203,      32'h0000BEEF, 2,
                    '{32'h200, 4'h8, 32'hEF000000},
                    '{32'h204, 4'h1, 32'h000000BE}};
        tbl[3]  = '{5'd10, 32'h32,       32'h000000A5, 1,
                    '{32'h30, 4'h4, 32'h00A50000}, '{0, 0, 0}};
        tbl[4]  = '{5'd5,  32'hFFFFFFFE, 32'hDEADBEEF, 2,
                    '{32'hFFFFFFFC, 4'hC, 32'hBEEF0000},
                    '{32'h0, 4'h3, 32'h0000DEAD}};
        tbl[5]  = '{5'd6,  32'h1001,     32'hFFFF1234, 1,
                    '{32'h1000, 4'h6, 32'h00123400}, '{0, 0, 0}};
        tbl[6]  = '{5'd9,  32'h7,        32'h123456C3, 1,
                    '{32'h4, 4'h8, 32'hC3000000}, '{0, 0, 0}};
        tbl[7]  = '{5'd0,  32'h40,       32'h12345678, 0,
                    '{0, 0, 0}, '{0, 0, 0}};
        tbl[8]  = '{5'd3,  32'h403,      32'h01020304, 2,
                    '{32'h400, 4'h8, 32'h04000000},
                    '{32'h404, 4'h7, 32'h00010203}};
        tbl[9]  = '{5'd31, 32'h3,        32'hFFFFFFFF, 0,
                    '{0, 0, 0}, '{0, 0, 0}};
        tbl[10] = '{5'd8,  32'h2,        32'h5555ABCD, 1,
                    '{32'h0, 4'hC, 32'hABCD0000}, '{0, 0, 0}};

        rst_n = 1'b0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        opcode = '0;
        addr = '0;
        data = '0;
        #12;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back to back with immediate ack.
        for (int i = 0; i < 11; i++) begin
            exp_q.delete();
            if (tbl[i].nb >= 1) exp_q.push_back(tbl[i].b1);
            if (tbl[i].nb == 2) exp_q.push_back(tbl[i].b2);
            do_store(tbl[i].op, tbl[i].a, tbl[i].d, 0, 0);
        end

        // Byte store with ack held off three cycles.
        exp_q.delete();
        exp_q.push_back('{32'h30, 4'h4, 32'h00A50000});
        do_store(5'd11, 32'h32, 32'h000000A5, 3, 3);
        @(negedge clk);
        chk("done_pulse", done, 0);

        // Ack with no request outstanding must not disturb anything.
        mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_req", mem_req, 0);
            chk("stray_ack_done", done, 0);
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 200; n++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] d;
            op = 5'($urandom_range(12, 0));
            if (($urandom & 7) == 0) op = 5'($urandom_range(31, 0));
            a = $urandom;
            d = $urandom;
            model(op, a, d);
            if ($urandom_range(3, 0) == 0) @(negedge clk);
            do_store(op, a, d, 0, 2);
        end

        // Reset while the second beat is outstanding.
        @(negedge clk);
        chk("pre_ready", in_ready, 1);
        in_valid = 1'b1;
        opcode = 5'd3;
        addr = 32'h101;
        data = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_b1_req", mem_req, 1);
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("abort_b2_req", mem_req, 1);
        chk("abort_b2_addr", mem_addr, 32'h104);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req_async", mem_req, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_misaligned", misaligned, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_req", mem_req, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_ready", in_ready, 1);
        end

        exp_q.delete();
        exp_q.push_back(tbl[0].b1);
        do_store(tbl[0].op, tbl[0].a, tbl[0].d, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
